// File: rtl/div_seq_ctrl.sv
// Sequencer and HI/LO owner for the iterative 32-cycle signed divider.
// Launches the divider, holds operands, commits results, and handles zero divisor, flush and watchdog.
module div_seq_ctrl #(
    parameter int unsigned TIMEOUT = 48,
    parameter logic [31:0] ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    output logic        req_ready,
    input  logic        flush,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_busy,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hilo_wdata,
    input  logic        hilo_rd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        WRITE  = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t         state_q;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;
    logic [31:0]    dividend_q;
    logic [31:0]    divisor_q;
    logic           start_q;
    logic           done_q;
    logic           err_q;
    logic           seen_busy_q;
    logic [TW-1:0]  timer_q;
    logic           busy_s;

    assign busy_s       = (state_q != IDLE);
    assign req_ready    = !busy_s;
    assign stall        = busy_s && (hilo_rd || hi_we || lo_we || req_valid);
    assign div_start    = start_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign done         = done_q;
    assign err          = err_q;

    // Controller FSM: owns HI/LO, operand latches, start pulse, watchdog and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            dividend_q  <= 32'd0;
            divisor_q   <= 32'd0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            seen_busy_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && !flush && (req_divisor == 32'd0)) begin
                        // Zero divisor resolves without the divider and overrides any MT write.
                        hi_q   <= req_dividend;
                        lo_q   <= ZERO_LO;
                        done_q <= 1'b1;
                    end else begin
                        if (hi_we) hi_q <= hilo_wdata;
                        if (lo_we) lo_q <= hilo_wdata;
                        if (req_valid && !flush) begin
                            dividend_q  <= req_dividend;
                            divisor_q   <= req_divisor;
                            start_q     <= 1'b1;
                            seen_busy_q <= 1'b0;
                            timer_q     <= '0;
                            state_q     <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    start_q <= 1'b0;
                    if (div_busy) seen_busy_q <= 1'b1;
                    state_q <= flush ? DRAIN : RUN;
                end
                RUN: begin
                    if (div_busy) seen_busy_q <= 1'b1;
                    timer_q <= timer_q + TW'(1);
                    if (flush) begin
                        state_q <= DRAIN;
                    end else if (seen_busy_q && !div_busy) begin
                        hi_q    <= div_r;
                        lo_q    <= div_q;
                        done_q  <= 1'b1;
                        state_q <= WRITE;
                    end else if (timer_q >= TIMER_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                DRAIN: begin
                    // Operands stay held until the divider finishes; its result is discarded.
                    if (div_busy) seen_busy_q <= 1'b1;
                    timer_q <= timer_q + TW'(1);
                    if (seen_busy_q && !div_busy) begin
                        state_q <= IDLE;
                    end else if (timer_q >= TIMER_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
